// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: 2-flop rx synchroniser, mid-bit sampling, valid/ready byte output.
// Optional parity check is enabled by defining UART_RX_PARITY_EN.
module uart_rx_oversampled #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned STOP_BITS  = 1
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic [CNT_W-1:0]     tick_cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 err;
  logic                 armed;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
  logic                 par_err_c;
`endif
  logic                 bit_tick_c;
  logic [CNT_W-1:0]     cnt_next_c;
  logic                 frame_done_c;
  logic                 final_err_c;

  // Two-flop synchroniser; idles high so reset looks like an idle line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign bit_tick_c   = tick && (tick_cnt == CNT_LAST);
  assign cnt_next_c   = (tick_cnt == CNT_LAST) ? '0 : tick_cnt + CNT_W'(1);
  assign frame_done_c = (state == S_STOP) && bit_tick_c && (stop_idx == STOP_LAST);
  assign final_err_c  = err | ~rx_s;
`ifdef UART_RX_PARITY_EN
  assign par_err_c    = ((^shreg) ^ par_bit) != PARITY_ODD;
`endif

  // Frame FSM; armed blocks re-triggering on a held-low (break) line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      err      <= 1'b0;
      armed    <= 1'b1;
      busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_s) armed <= 1'b1;
          if (tick && !rx_s && armed) begin
            state    <= S_START;
            tick_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        S_START: if (tick) begin
          if (tick_cnt == CNT_HALF) begin
            if (!rx_s) begin
              state    <= S_DATA;
              tick_cnt <= '0;
              bit_idx  <= '0;
              stop_idx <= 1'b0;
              err      <= 1'b0;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
          end
        end
        S_DATA: if (tick) begin
          tick_cnt <= cnt_next_c;
          if (bit_tick_c) begin
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + BIT_W'(1);
            if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: if (tick) begin
          tick_cnt <= cnt_next_c;
          if (bit_tick_c) begin
            par_bit <= rx_s;
            state   <= S_STOP;
          end
        end
`endif
        S_STOP: if (tick) begin
          tick_cnt <= cnt_next_c;
          if (bit_tick_c) begin
            err      <= final_err_c;
            stop_idx <= stop_idx + 1'b1;
            if (stop_idx == STOP_LAST) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              armed <= rx_s;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output handshake; a completion into an unaccepted byte is dropped and flagged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (rx_valid && rx_ready) overrun <= 1'b0;
      if (frame_done_c) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          frame_err  <= final_err_c;
          rx_valid   <= 1'b1;
`ifdef UART_RX_PARITY_EN
          parity_err <= par_err_c;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: tick every 4 clks, 16x oversampling, 64 clks per bit.
module tb_uart_rx_oversampled;

  localparam int unsigned BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif
  // Negedges from start-bit drive to rx_valid seen high: sync delay + tick phase + 152 ticks
  localparam int unsigned LAT_LO = 611 + PAR_BITS * 64;
  localparam int unsigned LAT_HI = 614 + PAR_BITS * 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  logic tick_at_pos = 1'b0;

  uart_rx_oversampled dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tick_at_pos <= tick;

  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_val, input logic par_flip);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^data) ^ par_flip;
    repeat (BIT_CLKS) @(negedge clk);
`else
    if (par_flip) $display("note: parity flip ignored without parity");
`endif
    rx = stop_val;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic expect_valid(input string name);
    int n = 0;
    while (!rx_valid && n < 1500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!rx_valid) begin
      errors++;
      $display("FAIL %s: rx_valid still 0 after %0d clks, required 1", name, n);
    end
  endtask

  task automatic accept();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  // Monitor: every transfer pops one expected byte
  always begin
    @(negedge clk);
    #1;
    if (rx_valid && rx_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_spurious: transfer of 0x%0h, required no transfer", rx_data);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_data", 32'(rx_data), 32'(mon_e.data));
        check("sb_frame_err", 32'(frame_err), 32'(mon_e.ferr));
`ifdef UART_RX_PARITY_EN
        check("sb_parity_err", 32'(parity_err), 32'(mon_e.perr));
`endif
      end
    end
  end

  initial begin
    int  n;
    bit  seen;
    reset    = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(rx_valid), 0);
    check("rst_data", 32'(rx_data), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Clean frame with latency measurement
    sb_q.push_back('{8'hA5, 1'b0, 1'b0});
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
    join_none
    n = 0;
    while (!rx_valid && n < 1500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n < int'(LAT_LO) || n > int'(LAT_HI)) begin
      errors++;
      $display("FAIL clean_latency: rx_valid after %0d clks, required %0d..%0d", n, LAT_LO, LAT_HI);
    end
    check("clean_tick_before_valid", 32'(tick_at_pos), 1);
    check("clean_data", 32'(rx_data), 32'h A5);
    check("clean_frame_err", 32'(frame_err), 0);
    wait fork;
    repeat (5) @(negedge clk);
    check("clean_valid_held", 32'(rx_valid), 1);
    accept();
    check("clean_valid_cleared", 32'(rx_valid), 0);
    repeat (BIT_CLKS) @(negedge clk);

    // Glitch shorter than half a bit
    seen = 1'b0;
    rx = 1'b0;
    repeat (20) begin @(negedge clk); if (busy) seen = 1'b1; end
    rx = 1'b1;
    repeat (60) begin @(negedge clk); if (busy) seen = 1'b1; end
    check("glitch_busy_pulsed", 32'(seen), 1);
    check("glitch_busy_low", 32'(busy), 0);
    check("glitch_no_valid", 32'(rx_valid), 0);

    // Framing error, then a clean frame
    sb_q.push_back('{8'h3C, 1'b1, 1'b0});
    send_frame(8'h3C, 1'b0, 1'b0);
    expect_valid("ferr_valid");
    check("ferr_flag", 32'(frame_err), 1);
    accept();
    repeat (2 * BIT_CLKS) @(negedge clk);
    sb_q.push_back('{8'h55, 1'b0, 1'b0});
    send_frame(8'h55, 1'b1, 1'b0);
    expect_valid("after_ferr_valid");
    check("after_ferr_flag", 32'(frame_err), 0);
    accept();
    repeat (BIT_CLKS) @(negedge clk);

    // Overrun: second back-to-back byte is dropped
    sb_q.push_back('{8'h11, 1'b0, 1'b0});
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    check("ovr_flag", 32'(overrun), 1);
    check("ovr_valid", 32'(rx_valid), 1);
    check("ovr_data_kept", 32'(rx_data), 32'h11);
    accept();
    check("ovr_cleared", 32'(overrun), 0);
    check("ovr_valid_cleared", 32'(rx_valid), 0);
    repeat (BIT_CLKS) @(negedge clk);

    // Reset in the middle of data bit 3 of 0xFF
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_valid", 32'(rx_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_overrun", 32'(overrun), 0);
    reset = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("postrst_no_valid", 32'(rx_valid), 0);
    check("postrst_idle", 32'(busy), 0);
    sb_q.push_back('{8'h81, 1'b0, 1'b0});
    send_frame(8'h81, 1'b1, 1'b0);
    expect_valid("postrst_valid");
    accept();
    repeat (BIT_CLKS) @(negedge clk);

    // Break: one all-zero frame with frame_err, no repeat while held low
    sb_q.push_back('{8'h00, 1'b1, 1'b0});
    rx = 1'b0;
    repeat (14 * BIT_CLKS) @(negedge clk);
    check("break_valid", 32'(rx_valid), 1);
    check("break_data", 32'(rx_data), 0);
    accept();
    repeat (12 * BIT_CLKS) @(negedge clk);
    check("break_no_repeat", 32'(rx_valid), 0);
    check("break_idle", 32'(busy), 0);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    // Even parity: correct then wrong parity bit on 0x07
    sb_q.push_back('{8'h07, 1'b0, 1'b0});
    send_frame(8'h07, 1'b1, 1'b0);
    expect_valid("par_ok_valid");
    check("par_ok_flag", 32'(parity_err), 0);
    accept();
    repeat (BIT_CLKS) @(negedge clk);
    sb_q.push_back('{8'h07, 1'b0, 1'b1});
    send_frame(8'h07, 1'b1, 1'b1);
    expect_valid("par_bad_valid");
    check("par_bad_flag", 32'(parity_err), 1);
    accept();
    repeat (BIT_CLKS) @(negedge clk);
`endif

    repeat (20) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
- UART receiver directly downstream of the baud tick generator.
- Consumes a single-cycle oversample tick at OVERSAMPLE × baud rate, for example 16 × 9600 from the 25 MHz clock.
- Synchronises the serial rx line, recovers 8N1 frames (start, DATA_BITS LSB-first, stop) with mid-bit sampling, and presents each byte on a valid/ready handshake with frame-error and overrun status.

Parameters:
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- OVERSAMPLE, 16: ticks per bit period; must be even, at least 8.
- STOP_BITS, 1: stop bits checked; 1 or 2.

Ports:
- clk  input  1  system clock (25 MHz).
- reset  input  1  asynchronous, active-high reset.
- tick  input  1  oversample strobe, one clk wide, from the baud generator.
- rx  input  1  asynchronous serial line; idle high.
- rx_data  output  DATA_BITS  received byte; stable while rx_valid is high.
- rx_valid  output  1  byte available; held until accepted.
- rx_ready  input  1  consumer accepts; a transfer occurs when rx_valid && rx_ready on a rising clk edge.
- frame_err  output  1  stop bit sampled low on the current byte; qualified by rx_valid.
- overrun  output  1  sticky: a new frame completed while rx_valid was still high.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset and clock: reset is asynchronous, active-high; clock is clk.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, state=IDLE, both sync flops=1.
- Synchronisation: rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s.
- Tick counting: tick_cnt has width $clog2(OVERSAMPLE) and advances only on cycles where tick=1.
- IDLE:
  - On tick with rx_s=0: go to START, tick_cnt=0.
- START:
  - Count ticks. When tick_cnt reaches OVERSAMPLE/2-1, sample rx_s.
  - If rx_s=0: go to DATA, tick_cnt=0, bit_idx=0.
  - If rx_s=1 (glitch): return to IDLE. No output change.
- DATA:
  - Every OVERSAMPLE ticks (tick_cnt wraps OVERSAMPLE-1→0), shift rx_s into shreg LSB-first.
  - After bit_idx=DATA_BITS-1: go to PARITY if enabled, otherwise STOP.
- STOP:
  - Sample rx_s after OVERSAMPLE ticks for each of the STOP_BITS stop bits.
  - err = any stop sample equal to 0.
  - After the final stop sample: go to IDLE. Do not wait for the end of the stop bit, so back-to-back frames are tolerated.
- Completion, on the clk following the final stop sample:
  - If rx_valid=0, or rx_valid && rx_ready in the same cycle: load rx_data=shreg, frame_err=err, rx_valid=1.
  - Otherwise keep the old rx_data and frame_err, and set overrun=1. The new byte is dropped.
- Handshake: rx_valid && rx_ready with no simultaneous completion clears rx_valid next cycle. frame_err is don't-care while rx_valid=0.
- overrun clearing: cleared only by reset or by a transfer (rx_valid && rx_ready).
- Latency: rx_valid rises exactly 1 clk after the tick on which the last stop bit is sampled.
- No-tick cycles: tick=0 freezes all counters, while the handshake logic keeps running every clk.
- Reset mid-frame: immediate return to IDLE with all outputs at reset values; the partial byte is discarded.
- rx held low (break): the frame completes with frame_err=1 and rx_data=0. The FSM re-enters START only after rx_s is seen high in IDLE, i.e. there is no repeated break reception.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Adds parameter PARITY_ODD (default 0 = even) and output parity_err (1 bit, reset 0, qualified by rx_valid).
  - Adds a PARITY state between DATA and STOP, sampling one bit after OVERSAMPLE ticks.
  - parity_err=1 when XOR(data bits, parity bit) != PARITY_ODD. It is loaded and held alongside frame_err.
- When undefined: no PARITY state, no parity_err port; the frame is start+data+stop only.

Test Plan:
- Bench setup common to all scenarios: tick driven every 4 clks, OVERSAMPLE=16, one bit = 64 clks.
- Clean frame: send 0xA5 8N1 with rx_ready=0 → rx_valid=1 and rx_data=0xA5 exactly 1 clk after the stop-sample tick; frame_err=0. Pulsing rx_ready for 1 clk → rx_valid=0 next clk.
- Glitch rejection: drive rx low for 20 clks (5 ticks < 8), then high → FSM returns to IDLE; rx_valid stays 0; busy pulses then drops.
- Framing error: send 0x3C with the stop bit forced 0 → rx_valid=1, rx_data=0x3C, frame_err=1. Then hold rx high and send 0x55 → frame_err=0.
- Overrun: send 0x11 then 0x22 back-to-back with rx_ready=0 → rx_data stays 0x11, overrun=1. Accepting with rx_ready → overrun=0, rx_valid=0.
- Reset mid-frame: assert reset at data bit 3 of 0xFF, release, then send 0x81 → rx_data=0x81 and no spurious rx_valid before it.
- Parity, with UART_RX_PARITY_EN and even parity: send 0x07 with parity bit 1 → parity_err=0; send 0x07 with parity bit 0 → parity_err=1.
